// File: rtl/key_matrix_pkg.sv
// Shared definitions for the keyboard-matrix row store: engine state encoding,
// event field packing width and the released-level pattern.
package key_matrix_pkg;

  localparam int unsigned MAX_COLS = 32;

  typedef logic [1:0] eng_state_t;

  localparam eng_state_t ST_IDLE  = 2'd0;
  localparam eng_state_t ST_APPLY = 2'd1;
  localparam eng_state_t ST_HOLD  = 2'd2;

  // Events are packed {press, row, col}, press in the MSB.
  function automatic int unsigned ev_width(input int unsigned aw, input int unsigned cw);
    return 1 + aw + cw;
  endfunction

  function automatic logic [MAX_COLS-1:0] rel_pattern(input bit active_low);
    return active_low ? {MAX_COLS{1'b1}} : {MAX_COLS{1'b0}};
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// Synchronous FIFO for queued host key events; extra pointer bit separates full from empty.
module key_event_fifo
  import key_matrix_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = (PW + 1)'(1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW:0]      r_wptr;
  logic [PW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);
  assign w_pop   = i_pop && !o_empty;
  // A pop in the same cycle frees the slot, so a full FIFO may still accept.
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_rdata = r_mem[r_rptr[PW-1:0]];

  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr[PW-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_ONE;
      if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/key_matrix_ram.sv
// Keyboard-matrix row store: CPU byte port, scanner row-combine port and a host event
// engine that applies each queued key event and then holds off for HOLD_CYC cycles.
module key_matrix_ram
  import key_matrix_pkg::*;
#(
  parameter int unsigned ROWS       = 8,
  parameter int unsigned COLS       = 8,
  parameter int unsigned ACTIVE_LOW = 0,
  parameter int unsigned EV_DEPTH   = 8,
  parameter int unsigned HOLD_CYC   = 1024,
  localparam int unsigned AW = $clog2(ROWS),
  localparam int unsigned CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic [AW-1:0]   A,
  input  logic            WR,
  input  logic [COLS-1:0] DI,
  output logic [COLS-1:0] DO,
  input  logic [ROWS-1:0] KEY_SEL,
  output logic [COLS-1:0] KEY_VAL,
  input  logic            EV_VALID,
  output logic            EV_READY,
  input  logic [AW-1:0]   EV_ROW,
  input  logic [CW-1:0]   EV_COL,
  input  logic            EV_PRESS,
  output logic            EV_BUSY
);

  localparam int unsigned         EVW     = ev_width(AW, CW);
  localparam int unsigned         HW      = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;
  localparam bit                  AL      = (ACTIVE_LOW != 0);
  localparam logic [MAX_COLS-1:0] REL_W   = rel_pattern(AL);
  localparam logic [COLS-1:0]     REL     = REL_W[COLS-1:0];
  localparam logic [AW:0]         ROWS_W  = (AW + 1)'(ROWS);
  localparam logic [CW:0]         COLS_W  = (CW + 1)'(COLS);
  localparam logic [HW-1:0]       HOLD_LD = HW'(HOLD_CYC - 1);
  localparam logic [HW-1:0]       HOLD_1  = HW'(1);

  logic [COLS-1:0] r_ram [ROWS];
  logic [COLS-1:0] w_ram_d [ROWS];
  logic [COLS-1:0] r_do;
  logic [COLS-1:0] r_key_val;
  logic [COLS-1:0] w_rd_row;
  logic [COLS-1:0] w_scan;
  logic            w_a_ok;
  logic            w_cpu_wr;

  eng_state_t      r_state;
  eng_state_t      w_state_d;
  logic [HW-1:0]   r_hold;
  logic [HW-1:0]   w_hold_d;
  logic [EVW-1:0]  r_ev;
  logic [EVW-1:0]  w_fifo_rdata;
  logic            w_fifo_full;
  logic            w_fifo_empty;
  logic            w_pop;
  logic            w_apply_go;
  logic [AW-1:0]   w_ev_row;
  logic [CW-1:0]   w_ev_col;
  logic            w_ev_ok;
  logic            w_ev_level;

  assign w_a_ok   = ({1'b0, A} < ROWS_W);
  assign w_cpu_wr = WR && w_a_ok;
  assign w_rd_row = w_a_ok ? r_ram[A] : REL;

  assign w_ev_row   = r_ev[CW +: AW];
  assign w_ev_col   = r_ev[CW-1:0];
  assign w_ev_ok    = ({1'b0, w_ev_row} < ROWS_W) && ({1'b0, w_ev_col} < COLS_W);
  assign w_ev_level = r_ev[EVW-1] ^ AL;

  key_event_fifo #(
    .WIDTH (EVW),
    .DEPTH (EV_DEPTH)
  ) u_fifo (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (EV_VALID && !w_fifo_full),
    .i_wdata ({EV_PRESS, EV_ROW, EV_COL}),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_comb begin
    w_scan = REL;
    for (int r = 0; r < ROWS; r++) begin
      if (KEY_SEL[r]) w_scan = AL ? (w_scan & r_ram[r]) : (w_scan | r_ram[r]);
    end
  end

  always_comb begin
    w_state_d  = r_state;
    w_hold_d   = r_hold;
    w_pop      = 1'b0;
    w_apply_go = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_pop     = 1'b1;
          w_state_d = ST_APPLY;
        end
      end
      ST_APPLY: begin
        // A CPU write to the same row wins; the engine retries on the next cycle.
        if (!(WR && (A == w_ev_row))) begin
          w_apply_go = 1'b1;
          w_hold_d   = HOLD_LD;
          w_state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (r_hold == '0) w_state_d = ST_IDLE;
        else              w_hold_d  = r_hold - HOLD_1;
      end
      default: w_state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      w_ram_d[r] = r_ram[r];
      if (w_cpu_wr && (A == AW'(r))) w_ram_d[r] = DI;
      if (w_apply_go && w_ev_ok && (w_ev_row == AW'(r))) w_ram_d[r][w_ev_col] = w_ev_level;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int r = 0; r < ROWS; r++) r_ram[r] <= REL;
      r_do      <= '0;
      r_key_val <= REL;
      r_state   <= ST_IDLE;
      r_hold    <= '0;
      r_ev      <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) r_ram[r] <= w_ram_d[r];
      r_do      <= w_rd_row;
      r_key_val <= w_scan;
      r_state   <= w_state_d;
      r_hold    <= w_hold_d;
      if (w_pop) r_ev <= w_fifo_rdata;
    end
  end

  assign DO       = r_do;
  assign KEY_VAL  = r_key_val;
  assign EV_READY = !w_fifo_full;
  assign EV_BUSY  = !w_fifo_empty || (r_state != ST_IDLE);

endmodule

// File: tb/tb_key_matrix_ram.sv
// Scenario bench for key_matrix_ram: an active-high instance carries the event tests,
// an active-low instance checks the AND combine and all-ones released level.
module tb_key_matrix_ram;

  localparam int unsigned HOLD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] a = '0, ev_row = '0, ev_col = '0;
  logic       wr = 1'b0, ev_valid = 1'b0, ev_press = 1'b0;
  logic [7:0] di = '0, key_sel = '0;
  logic [7:0] do_, key_val;
  logic       ev_ready, ev_busy;

  logic [2:0] al_a = '0, al_ev_row = '0, al_ev_col = '0;
  logic       al_wr = 1'b0, al_ev_valid = 1'b0, al_ev_press = 1'b0;
  logic [7:0] al_di = '0, al_key_sel = '0;
  logic [7:0] al_do, al_key_val;
  logic       al_ev_ready, al_ev_busy;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  key_matrix_ram #(
    .ROWS(8), .COLS(8), .ACTIVE_LOW(0), .EV_DEPTH(8), .HOLD_CYC(HOLD)
  ) u_dut (
    .CLK(clk), .RESET(rst), .A(a), .WR(wr), .DI(di), .DO(do_),
    .KEY_SEL(key_sel), .KEY_VAL(key_val), .EV_VALID(ev_valid), .EV_READY(ev_ready),
    .EV_ROW(ev_row), .EV_COL(ev_col), .EV_PRESS(ev_press), .EV_BUSY(ev_busy)
  );

  key_matrix_ram #(
    .ROWS(8), .COLS(8), .ACTIVE_LOW(1), .EV_DEPTH(8), .HOLD_CYC(HOLD)
  ) u_dut_al (
    .CLK(clk), .RESET(rst), .A(al_a), .WR(al_wr), .DI(al_di), .DO(al_do),
    .KEY_SEL(al_key_sel), .KEY_VAL(al_key_val), .EV_VALID(al_ev_valid),
    .EV_READY(al_ev_ready), .EV_ROW(al_ev_row), .EV_COL(al_ev_col),
    .EV_PRESS(al_ev_press), .EV_BUSY(al_ev_busy)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    a = '0; wr = 1'b0; di = '0; key_sel = '0;
    ev_valid = 1'b0; ev_row = '0; ev_col = '0; ev_press = 1'b0;
    al_a = '0; al_wr = 1'b0; al_di = '0; al_key_sel = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic cpu_write(input logic [2:0] addr, input logic [7:0] data);
    a = addr; wr = 1'b1; di = data;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic al_write(input logic [2:0] addr, input logic [7:0] data);
    al_a = addr; al_wr = 1'b1; al_di = data;
    @(negedge clk);
    al_wr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (key_val !== 8'h00) begin failures++;
      $display("FAIL reset_key_val: got %h expected 00", key_val); end
    checks++; if (do_ !== 8'h00) begin failures++;
      $display("FAIL reset_do: got %h expected 00", do_); end
    checks++; if (ev_busy !== 1'b0 || ev_ready !== 1'b1) begin failures++;
      $display("FAIL reset_ev: got busy=%b ready=%b expected busy=0 ready=1", ev_busy, ev_ready); end
    checks++; if (al_key_val !== 8'hFF || al_do !== 8'h00) begin failures++;
      $display("FAIL reset_al: got key_val=%h do=%h expected FF 00", al_key_val, al_do); end
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = 3'(i); al_a = 3'(i);
      exp_q.push_back(8'h00);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (do_ !== exp_v) begin failures++;
        $display("FAIL reset_row%0d: got %h expected %h", i, do_, exp_v); end
      checks++; if (al_do !== 8'hFF) begin failures++;
        $display("FAIL reset_al_row%0d: got %h expected FF", i, al_do); end
    end
  endtask

  task automatic test_cpu_rw();
    apply_reset();
    a = 3'd3; wr = 1'b1; di = 8'h5A;
    exp_q.push_back(8'h00);  // write cycle returns the old contents
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (do_ !== exp_v) begin failures++;
      $display("FAIL rw_old_data: got %h expected %h", do_, exp_v); end
    wr = 1'b0;
    exp_q.push_back(8'h5A);
    @(negedge clk);
    exp_v = exp_q.pop_front();
    checks++; if (do_ !== exp_v) begin failures++;
      $display("FAIL rw_readback: got %h expected %h", do_, exp_v); end
    key_sel = 8'h08;
    @(negedge clk);
    checks++; if (key_val !== 8'h5A) begin failures++;
      $display("FAIL rw_scan_row3: got %h expected 5A", key_val); end
  endtask

  task automatic test_scan_combine();
    logic [7:0] sel [3] = '{8'h06, 8'h02, 8'h00};
    logic [7:0] hi_exp [3] = '{8'hFF, 8'h0F, 8'h00};
    logic [7:0] lo_exp [3] = '{8'h7E, 8'hFE, 8'hFF};
    apply_reset();
    cpu_write(3'd1, 8'h0F);
    cpu_write(3'd2, 8'hF0);
    al_write(3'd1, 8'hFE);
    al_write(3'd2, 8'h7F);
    for (int i = 0; i < 3; i++) begin
      key_sel = sel[i]; al_key_sel = sel[i];
      @(negedge clk);
      checks++; if (key_val !== hi_exp[i]) begin failures++;
        $display("FAIL scan_or sel=%h: got %h expected %h", sel[i], key_val, hi_exp[i]); end
      checks++; if (al_key_val !== lo_exp[i]) begin failures++;
        $display("FAIL scan_and sel=%h: got %h expected %h", sel[i], al_key_val, lo_exp[i]); end
    end
  endtask

  task automatic test_event_hold();
    int bit_cnt = 0;
    int busy_cnt = 0;
    apply_reset();
    a = 3'd2;
    ev_valid = 1'b1; ev_row = 3'd2; ev_col = 3'd5; ev_press = 1'b1;
    @(negedge clk);
    busy_cnt += int'(ev_busy); bit_cnt += int'(do_[5]);
    ev_press = 1'b0;
    @(negedge clk);
    busy_cnt += int'(ev_busy); bit_cnt += int'(do_[5]);
    ev_valid = 1'b0;
    repeat (40) begin
      @(negedge clk);
      busy_cnt += int'(ev_busy); bit_cnt += int'(do_[5]);
    end
    // Press is visible from its APPLY edge until the release's APPLY edge.
    checks++; if (bit_cnt != int'(HOLD + 2)) begin failures++;
      $display("FAIL hold_pressed_cycles: got %0d expected %0d", bit_cnt, HOLD + 2); end
    checks++; if (busy_cnt != int'(2 * (HOLD + 2))) begin failures++;
      $display("FAIL hold_busy_cycles: got %0d expected %0d", busy_cnt, 2 * (HOLD + 2)); end
    checks++; if (do_ !== 8'h00 || ev_busy !== 1'b0) begin failures++;
      $display("FAIL hold_final: got row=%h busy=%b expected 00 0", do_, ev_busy); end
  endtask

  task automatic test_fifo_full();
    logic [7:0] row_exp [8] = '{8'h02, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h00};
    int waited = 0;
    apply_reset();
    // Blocker event stuck in APPLY by a CPU write to its row while the FIFO fills.
    a = 3'd0; wr = 1'b1; di = 8'h00;
    ev_valid = 1'b1; ev_row = 3'd0; ev_col = 3'd1; ev_press = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      ev_row = 3'(i); ev_col = 3'(i); ev_press = (i != 7);
      if (i == 7) ev_row = 3'd0;
      if (i == 7) ev_col = 3'd0;
    end
    @(negedge clk);
    checks++; if (ev_ready !== 1'b0) begin failures++;
      $display("FAIL fifo_full_ready: got %b expected 0", ev_ready); end
    ev_row = 3'd1; ev_col = 3'd7; ev_press = 1'b1;
    @(negedge clk);
    checks++; if (ev_ready !== 1'b0) begin failures++;
      $display("FAIL fifo_full_hold: got %b expected 0", ev_ready); end
    ev_valid = 1'b0; wr = 1'b0;
    while (ev_busy === 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    checks++; if (ev_busy !== 1'b0) begin failures++;
      $display("FAIL fifo_drain_timeout: got busy=%b after %0d cycles expected 0", ev_busy, waited); end
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      exp_q.push_back(row_exp[i]);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (do_ !== exp_v) begin failures++;
        $display("FAIL fifo_order_row%0d: got %h expected %h", i, do_, exp_v); end
    end
  endtask

  task automatic test_cpu_conflict();
    apply_reset();
    a = 3'd2;
    ev_valid = 1'b1; ev_row = 3'd2; ev_col = 3'd3; ev_press = 1'b1;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    wr = 1'b1; di = 8'h81;  // lands in the engine's APPLY cycle for row 2
    @(negedge clk);
    wr = 1'b0;
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h89);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (do_ !== exp_v) begin failures++;
        $display("FAIL conflict_step%0d: got %h expected %h", i, do_, exp_v); end
    end
  endtask

  task automatic test_reset_mid_hold();
    int busy_cnt = 0;
    apply_reset();
    a = 3'd4;
    ev_valid = 1'b1; ev_row = 3'd4; ev_col = 3'd4; ev_press = 1'b1;
    @(negedge clk);
    ev_row = 3'd5; ev_col = 3'd5;
    @(negedge clk);
    ev_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ev_busy !== 1'b1 || do_ !== 8'h10) begin failures++;
      $display("FAIL midhold_pre: got busy=%b row4=%h expected 1 10", ev_busy, do_); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (ev_busy !== 1'b0 || ev_ready !== 1'b1) begin failures++;
      $display("FAIL midhold_reset: got busy=%b ready=%b expected 0 1", ev_busy, ev_ready); end
    repeat (20) begin
      @(negedge clk);
      busy_cnt += int'(ev_busy);
    end
    checks++; if (busy_cnt != 0) begin failures++;
      $display("FAIL midhold_discard: got %0d busy cycles expected 0", busy_cnt); end
    for (int i = 4; i < 6; i++) begin
      a = 3'(i);
      exp_q.push_back(8'h00);
      @(negedge clk);
      exp_v = exp_q.pop_front();
      checks++; if (do_ !== exp_v) begin failures++;
        $display("FAIL midhold_row%0d: got %h expected %h", i, do_, exp_v); end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_rw();
    test_scan_combine();
    test_event_hold();
    test_fifo_full();
    test_cpu_conflict();
    test_reset_mid_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
